// File: rtl/lsu_pkg.sv
// Shared load/store-unit types: LDQ entry layout, queue depths and load-exec FSM states.
package lsu_pkg;

    localparam int unsigned LDQ_ENTRIES = 8;
    localparam int unsigned SDQ_ENTRIES = 8;
    // One extra wrap bit lets the SDQ order markers across pointer wrap-around.
    localparam int unsigned MARKER_W    = $clog2(SDQ_ENTRIES) + 1;

    typedef struct packed {
        logic                valid;
        logic                addr_valid;
        logic [31:0]         addr;
        logic [MARKER_W-1:0] sdq_marker;
        logic                issued;
    } ldq_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        REQ,
        RESP,
        WB
    } lexc_state_e;

endpackage

// File: rtl/load_exec_unit_if.sv
// Bundles the issue, SDQ-forwarding, data-cache and writeback ports of the load execution unit.
interface load_exec_unit_if;
    import lsu_pkg::*;

    logic                issue_vld;
    ldq_entry_t          issue_entry;
    logic                issue_en;

    logic                sdq_q_vld;
    logic [31:0]         sdq_q_addr;
    logic [MARKER_W-1:0] sdq_q_marker;
    logic                sdq_q_hit;
    logic [31:0]         sdq_q_data;
    logic                sdq_q_stall;

    logic                dc_req_vld;
    logic [31:0]         dc_req_addr;
    logic                dc_req_rdy;
    logic                dc_resp_vld;
    logic [31:0]         dc_resp_data;

    logic                wb_vld;
    ldq_entry_t          wb_entry;
    logic [31:0]         wb_data;
    logic                wb_misalign;
    logic                wb_rdy;

    // Environment side: LDQ, SDQ, data cache and writeback consumer.
    modport master (
        output issue_vld, issue_entry, sdq_q_hit, sdq_q_data, sdq_q_stall,
               dc_req_rdy, dc_resp_vld, dc_resp_data, wb_rdy,
        input  issue_en, sdq_q_vld, sdq_q_addr, sdq_q_marker, dc_req_vld, dc_req_addr,
               wb_vld, wb_entry, wb_data, wb_misalign
    );

    // Load execution unit side.
    modport slave (
        input  issue_vld, issue_entry, sdq_q_hit, sdq_q_data, sdq_q_stall,
               dc_req_rdy, dc_resp_vld, dc_resp_data, wb_rdy,
        output issue_en, sdq_q_vld, sdq_q_addr, sdq_q_marker, dc_req_vld, dc_req_addr,
               wb_vld, wb_entry, wb_data, wb_misalign
    );

endinterface

// File: rtl/load_exec_unit_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/load_exec_unit.sv
// Single-in-flight load executor: SDQ forward check, else data-cache read, then writeback.
module load_exec_unit
    import lsu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    load_exec_unit_if.slave  io_bus,
    output logic [CNT_W-1:0] o_cnt_fwd,
    output logic [CNT_W-1:0] o_cnt_dc,
    output logic [CNT_W-1:0] o_cnt_stall
);

    lexc_state_e r_state;
    lexc_state_e w_state_next;
    ldq_entry_t  r_entry;
    logic [31:0] r_data;
    logic        r_misalign;
    logic        w_fwd_inc;
    logic        w_dc_inc;
    logic        w_stall_inc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (io_bus.issue_vld) begin
                    w_state_next = (io_bus.issue_entry.addr[1:0] != 2'b00) ? WB : FWD;
                end
            end
            FWD: begin
                // An unresolved older store blocks both forwarding and the cache path.
                if (!io_bus.sdq_q_stall) begin
                    w_state_next = io_bus.sdq_q_hit ? WB : REQ;
                end
            end
            REQ: begin
                if (io_bus.dc_req_rdy) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (io_bus.dc_resp_vld) begin
                    w_state_next = WB;
                end
            end
            WB: begin
                if (io_bus.wb_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        io_bus.issue_en    = (r_state == IDLE);
        io_bus.sdq_q_vld   = (r_state == FWD);
        io_bus.sdq_q_addr  = r_entry.addr;
        io_bus.sdq_q_marker = r_entry.sdq_marker;
        io_bus.dc_req_vld  = (r_state == REQ);
        io_bus.dc_req_addr = {r_entry.addr[31:2], 2'b00};
        io_bus.wb_vld      = (r_state == WB);
        io_bus.wb_entry    = r_entry;
        io_bus.wb_data     = r_data;
        io_bus.wb_misalign = r_misalign;
        w_fwd_inc   = (r_state == FWD) && !io_bus.sdq_q_stall && io_bus.sdq_q_hit;
        w_stall_inc = (r_state == FWD) && io_bus.sdq_q_stall;
        w_dc_inc    = (r_state == REQ) && io_bus.dc_req_rdy;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry    <= '0;
            r_data     <= '0;
            r_misalign <= 1'b0;
        end else begin
            if ((r_state == IDLE) && io_bus.issue_vld) begin
                r_entry    <= io_bus.issue_entry;
                r_data     <= '0;
                r_misalign <= (io_bus.issue_entry.addr[1:0] != 2'b00);
            end
            if (w_fwd_inc) begin
                r_data <= io_bus.sdq_q_data;
            end
            if ((r_state == RESP) && io_bus.dc_resp_vld) begin
                r_data <= io_bus.dc_resp_data;
            end
            if ((r_state == WB) && io_bus.wb_rdy) begin
                r_misalign <= 1'b0;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_fwd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_fwd_inc),
        .o_count (o_cnt_fwd)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_dc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_dc_inc),
        .o_count (o_cnt_dc)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_stall_inc),
        .o_count (o_cnt_stall)
    );

endmodule

// File: tb/tb_load_exec_unit.sv
// Randomized self-checking bench for load_exec_unit against a cycle-schedule reference model.
module tb_load_exec_unit;
    import lsu_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_exec_unit_if bus ();
    logic [CNT_W-1:0] cnt_fwd;
    logic [CNT_W-1:0] cnt_dc;
    logic [CNT_W-1:0] cnt_stall;

    int checks   = 0;
    int failures = 0;
    int m_fwd    = 0;
    int m_dc     = 0;
    int m_stall  = 0;

    load_exec_unit #(.CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_bus      (bus),
        .o_cnt_fwd   (cnt_fwd),
        .o_cnt_dc    (cnt_dc),
        .o_cnt_stall (cnt_stall)
    );

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic drive_idle();
        bus.issue_vld    = 1'b0;
        bus.issue_entry  = '0;
        bus.sdq_q_hit    = 1'b0;
        bus.sdq_q_data   = '0;
        bus.sdq_q_stall  = 1'b0;
        bus.dc_req_rdy   = 1'b0;
        bus.dc_resp_vld  = 1'b0;
        bus.dc_resp_data = '0;
        bus.wb_rdy       = 1'b0;
    endtask

    // Expected behaviour from issue cycle c=0: s stall cycles in FWD, then hit or a cache
    // access with r request-wait and p response-wait cycles; writeback held w cycles.
    task automatic do_load(input ldq_entry_t e, input int s, input bit hit,
                           input logic [31:0] hd, input int r, input int p,
                           input logic [31:0] rd, input int w, input string tag);
        bit          mis, in_fwd, in_req, in_resp, in_wb;
        int          wbt, last;
        logic [31:0] exp_data;
        ldq_entry_t  junk;
        mis      = (e.addr[1:0] != 2'b00);
        wbt      = mis ? 1 : (hit ? s + 2 : s + 4 + r + p);
        last     = wbt + w;
        exp_data = mis ? 32'h0 : (hit ? hd : rd);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            in_fwd  = !mis && (c >= 1) && (c <= s + 1);
            in_req  = !mis && !hit && (c >= s + 2) && (c <= s + 2 + r);
            in_resp = !mis && !hit && (c >= s + 3 + r) && (c <= s + 3 + r + p);
            in_wb   = (c >= wbt);
            junk      = e;
            junk.addr = $urandom;
            bus.issue_vld    = (c == 0);
            bus.issue_entry  = (c == 0) ? e : junk;
            bus.sdq_q_stall  = in_fwd ? (c <= s) : 1'($urandom);
            bus.sdq_q_hit    = (in_fwd && c == s + 1) ? hit : 1'($urandom);
            bus.sdq_q_data   = (in_fwd && c == s + 1) ? hd : $urandom;
            bus.dc_req_rdy   = in_req ? (c == s + 2 + r) : 1'($urandom);
            bus.dc_resp_vld  = in_resp ? (c == s + 3 + r + p) : 1'($urandom);
            bus.dc_resp_data = (in_resp && c == s + 3 + r + p) ? rd : $urandom;
            bus.wb_rdy       = in_wb ? (c == last) : 1'($urandom);
            checks++;
            if (bus.issue_en !== (c == 0)) begin
                failures++;
                $display("FAIL %s issue_en c=%0d got=%b exp=%b", tag, c, bus.issue_en, c == 0);
            end
            checks++;
            if (bus.sdq_q_vld !== in_fwd) begin
                failures++;
                $display("FAIL %s sdq_q_vld c=%0d got=%b exp=%b", tag, c, bus.sdq_q_vld, in_fwd);
            end
            checks++;
            if (bus.dc_req_vld !== in_req) begin
                failures++;
                $display("FAIL %s dc_req_vld c=%0d got=%b exp=%b", tag, c, bus.dc_req_vld, in_req);
            end
            checks++;
            if (bus.wb_vld !== in_wb) begin
                failures++;
                $display("FAIL %s wb_vld c=%0d got=%b exp=%b", tag, c, bus.wb_vld, in_wb);
            end
            if (in_fwd) begin
                checks++;
                if ((bus.sdq_q_addr !== e.addr) || (bus.sdq_q_marker !== e.sdq_marker)) begin
                    failures++;
                    $display("FAIL %s sdq_query c=%0d got=%h/%h exp=%h/%h", tag, c,
                             bus.sdq_q_addr, bus.sdq_q_marker, e.addr, e.sdq_marker);
                end
            end
            if (in_req) begin
                checks++;
                if (bus.dc_req_addr !== {e.addr[31:2], 2'b00}) begin
                    failures++;
                    $display("FAIL %s dc_req_addr c=%0d got=%h exp=%h", tag, c,
                             bus.dc_req_addr, {e.addr[31:2], 2'b00});
                end
            end
            if (in_wb) begin
                checks++;
                if ((bus.wb_data !== exp_data) || (bus.wb_misalign !== mis) ||
                    (bus.wb_entry !== e)) begin
                    failures++;
                    $display("FAIL %s wb_out c=%0d got=%h/%b/%h exp=%h/%b/%h", tag, c,
                             bus.wb_data, bus.wb_misalign, bus.wb_entry, exp_data, mis, e);
                end
            end
        end
        @(negedge clk);
        drive_idle();
        if (!mis) begin
            if (hit) m_fwd = sat_add(m_fwd, 1);
            else     m_dc  = sat_add(m_dc, 1);
            m_stall = sat_add(m_stall, s);
        end
        checks++;
        if ((bus.issue_en !== 1'b1) || (bus.wb_vld !== 1'b0)) begin
            failures++;
            $display("FAIL %s after_wb got issue_en=%b wb_vld=%b exp 1/0", tag, bus.issue_en,
                     bus.wb_vld);
        end
        checks++;
        if ((cnt_fwd !== CNT_W'(m_fwd)) || (cnt_dc !== CNT_W'(m_dc)) ||
            (cnt_stall !== CNT_W'(m_stall))) begin
            failures++;
            $display("FAIL %s counters got=%0d/%0d/%0d exp=%0d/%0d/%0d", tag, cnt_fwd, cnt_dc,
                     cnt_stall, m_fwd, m_dc, m_stall);
        end
    endtask

    function automatic ldq_entry_t mk_entry(input logic [31:0] addr);
        ldq_entry_t e;
        e.valid      = 1'b1;
        e.addr_valid = 1'b1;
        e.addr       = addr;
        e.sdq_marker = MARKER_W'($urandom);
        e.issued     = 1'b1;
        return e;
    endfunction

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_fwd = 0; m_dc = 0; m_stall = 0;
        checks++;
        if ((bus.issue_en !== 1'b1) || (bus.sdq_q_vld !== 1'b0) || (bus.dc_req_vld !== 1'b0) ||
            (bus.wb_vld !== 1'b0) || (bus.wb_misalign !== 1'b0)) begin
            failures++;
            $display("FAIL reset_ctrl got en=%b sdq=%b dc=%b wb=%b mis=%b exp 1/0/0/0/0",
                     bus.issue_en, bus.sdq_q_vld, bus.dc_req_vld, bus.wb_vld, bus.wb_misalign);
        end
        checks++;
        if ((bus.wb_data !== 32'h0) || (bus.wb_entry !== '0) || (bus.sdq_q_addr !== 32'h0) ||
            (bus.dc_req_addr !== 32'h0)) begin
            failures++;
            $display("FAIL reset_data got data=%h entry=%h qaddr=%h daddr=%h exp all 0",
                     bus.wb_data, bus.wb_entry, bus.sdq_q_addr, bus.dc_req_addr);
        end
        checks++;
        if ((cnt_fwd !== '0) || (cnt_dc !== '0) || (cnt_stall !== '0)) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cnt_fwd, cnt_dc, cnt_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_cache_load();
        do_load(mk_entry(32'h100), 0, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 0, "cache_load");
    endtask

    task automatic test_forward();
        do_load(mk_entry(32'h200), 0, 1'b1, 32'h12345678, 0, 0, 32'h0, 0, "forward");
    endtask

    task automatic test_stall_then_hit();
        do_load(mk_entry(32'h204), 3, 1'b1, 32'hA5A5A5A5, 0, 0, 32'h0, 0, "stall_hit");
    endtask

    task automatic test_misalign();
        do_load(mk_entry(32'h102), 0, 1'b0, 32'h0, 0, 0, 32'h0, 0, "misalign");
    endtask

    task automatic test_backpressure();
        do_load(mk_entry(32'h400), 0, 1'b0, 32'h0, 4, 0, 32'hCAFEF00D, 2, "backpressure");
    endtask

    task automatic test_random();
        ldq_entry_t e;
        for (int i = 0; i < 40; i++) begin
            e = mk_entry($urandom);
            if ($urandom_range(3) != 0) e.addr[1:0] = 2'b00;
            do_load(e, int'($urandom_range(3)), 1'($urandom), $urandom, int'($urandom_range(3)),
                    int'($urandom_range(3)), $urandom, int'($urandom_range(2)), "random");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.issue_vld   = 1'b1;
        bus.issue_entry = mk_entry(32'h300);
        @(negedge clk);
        bus.issue_vld   = 1'b0;
        bus.sdq_q_stall = 1'b0;
        bus.sdq_q_hit   = 1'b0;
        @(negedge clk);
        bus.dc_req_rdy  = 1'b1;
        @(negedge clk);
        bus.dc_req_rdy  = 1'b0;
        checks++;
        if ((bus.dc_req_vld !== 1'b0) || (bus.wb_vld !== 1'b0) || (bus.issue_en !== 1'b0)) begin
            failures++;
            $display("FAIL rst_mid_resp got dc=%b wb=%b en=%b exp 0/0/0", bus.dc_req_vld,
                     bus.wb_vld, bus.issue_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_fwd = 0; m_dc = 0; m_stall = 0;
        bus.dc_resp_vld  = 1'b1;
        bus.dc_resp_data = 32'h0BADF00D;
        checks++;
        if ((bus.issue_en !== 1'b1) || (bus.wb_vld !== 1'b0) || (bus.wb_data !== 32'h0)) begin
            failures++;
            $display("FAIL rst_mid_after got en=%b wb=%b data=%h exp 1/0/0", bus.issue_en,
                     bus.wb_vld, bus.wb_data);
        end
        checks++;
        if ((cnt_fwd !== '0) || (cnt_dc !== '0) || (cnt_stall !== '0)) begin
            failures++;
            $display("FAIL rst_mid_counters got=%0d/%0d/%0d exp=0/0/0", cnt_fwd, cnt_dc,
                     cnt_stall);
        end
        @(negedge clk);
        bus.dc_resp_vld = 1'b0;
        checks++;
        if ((bus.wb_vld !== 1'b0) || (bus.issue_en !== 1'b1) || (bus.wb_data !== 32'h0)) begin
            failures++;
            $display("FAIL rst_mid_stray_resp got wb=%b en=%b data=%h exp 0/1/0", bus.wb_vld,
                     bus.issue_en, bus.wb_data);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_cache_load();
        test_forward();
        test_stall_then_hit();
        test_misalign();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
